// File: rtl/y86_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// y86_fetch_unit_pkg: Y86-64 icode/stat constants and fetch FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y86_fetch_unit_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH_OP    = 3'd0,
    ST_FETCH_REG   = 3'd1,
    ST_FETCH_CONST = 3'd2,
    ST_DONE        = 3'd3,
    ST_WAIT_PC     = 3'd4,
    ST_HALTED      = 3'd5
  } fetch_state_e;

  // Byte length of an instruction: opcode byte, optional regid byte, optional 8-byte constant.
  function automatic logic [63:0] instr_len(input logic need_regids, input logic need_valc);
    return 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/y86_predecode.sv
// ---------------------------------------------------------------------------
// y86_predecode: icode -> legality and operand-byte requirements.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y86_predecode (
  input  logic [3:0] icode,
  output logic       instr_valid,
  output logic       need_regids,
  output logic       need_valc
);
  import y86_fetch_unit_pkg::*;

  always_comb begin
    instr_valid = 1'b1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      IHALT, INOP, IRET: begin
      end
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        need_regids = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      IJXX, ICALL: begin
        need_valc = 1'b1;
      end
      default: begin
        instr_valid = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/y86_fetch_unit.sv
// ---------------------------------------------------------------------------
// y86_fetch_unit: byte-serial Y86-64 instruction fetch with valid/ready output.
// Optional imem watchdog: FETCH_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y86_fetch_unit #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [7:0]  imem_rdata_i,
  input  logic        imem_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic [63:0] pc_o,
  input  logic        pc_load_i,
  input  logic [63:0] pc_next_i,
  output logic [2:0]  stat_o
);
  import y86_fetch_unit_pkg::*;

  fetch_state_e state;
  logic         req;
  logic         valid;
  logic [63:0]  pc;
  logic [63:0]  valc;
  logic [63:0]  valp;
  logic [63:0]  addr;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [3:0]   ra;
  logic [3:0]   rb;
  logic [2:0]   stat;
  logic [2:0]   kcnt;
  logic         need_regids;
  logic         need_valc;
  logic         pd_valid;
  logic         pd_regids;
  logic         pd_valc;
  logic         retire;
  logic         load_pc;
  logic         timeout;

  y86_predecode u_predecode (
    .icode       (imem_rdata_i[7:4]),
    .instr_valid (pd_valid),
    .need_regids (pd_regids),
    .need_valc   (pd_valc)
  );

  assign retire  = (state == ST_DONE) && instr_ready_i;
  // A next-PC strobe only counts when the unit is actually waiting for one.
  assign load_pc = pc_load_i &&
                   ((state == ST_WAIT_PC) ||
                    (retire && (stat == SAOK) && (icode != IHALT)));

  always_comb begin
    addr = pc;
    case (state)
      ST_FETCH_REG:   addr = pc + 64'd1;
      ST_FETCH_CONST: addr = pc + (need_regids ? 64'd2 : 64'd1) + {61'd0, kcnt};
      default:        addr = pc;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !req || imem_rvalid_i || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign timeout = req && !imem_rvalid_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_FETCH_OP;
      pc          <= RESET_PC;
      req         <= 1'b0;
      valid       <= 1'b0;
      icode       <= IHALT;
      ifun        <= 4'h0;
      ra          <= RNONE;
      rb          <= RNONE;
      valc        <= 64'd0;
      valp        <= 64'd0;
      stat        <= SAOK;
      kcnt        <= 3'd0;
      need_regids <= 1'b0;
      need_valc   <= 1'b0;
    end else if (load_pc) begin
      state       <= ST_FETCH_OP;
      pc          <= pc_next_i;
      req         <= 1'b0;
      valid       <= 1'b0;
      icode       <= IHALT;
      ifun        <= 4'h0;
      ra          <= RNONE;
      rb          <= RNONE;
      valc        <= 64'd0;
      valp        <= 64'd0;
      stat        <= SAOK;
      kcnt        <= 3'd0;
      need_regids <= 1'b0;
      need_valc   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH_OP, ST_FETCH_REG, ST_FETCH_CONST: begin
          if (!req) begin
            req <= 1'b1;
          end else if (imem_rvalid_i && imem_err_i) begin
            stat  <= SADR;
            req   <= 1'b0;
            valid <= 1'b1;
            state <= ST_DONE;
          end else if (imem_rvalid_i) begin
            if (state == ST_FETCH_OP) begin
              icode       <= imem_rdata_i[7:4];
              ifun        <= imem_rdata_i[3:0];
              need_regids <= pd_regids;
              need_valc   <= pd_valc;
              valp        <= pc + instr_len(pd_regids, pd_valc);
              if (!pd_valid) begin
                stat  <= SINS;
                req   <= 1'b0;
                valid <= 1'b1;
                state <= ST_DONE;
              end else if (pd_regids) begin
                state <= ST_FETCH_REG;
              end else if (pd_valc) begin
                state <= ST_FETCH_CONST;
              end else begin
                req   <= 1'b0;
                valid <= 1'b1;
                state <= ST_DONE;
              end
            end else if (state == ST_FETCH_REG) begin
              ra <= imem_rdata_i[7:4];
              rb <= imem_rdata_i[3:0];
              if (need_valc) begin
                state <= ST_FETCH_CONST;
              end else begin
                req   <= 1'b0;
                valid <= 1'b1;
                state <= ST_DONE;
              end
            end else begin
              valc[{kcnt, 3'b000} +: 8] <= imem_rdata_i;
              kcnt <= kcnt + 3'd1;
              if (kcnt == 3'd7) begin
                req   <= 1'b0;
                valid <= 1'b1;
                state <= ST_DONE;
              end
            end
          end else if (timeout) begin
            stat  <= SADR;
            req   <= 1'b0;
            valid <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (retire) begin
            valid <= 1'b0;
            if (stat != SAOK) begin
              state <= ST_HALTED;
            end else if (icode == IHALT) begin
              stat  <= SHLT;
              state <= ST_HALTED;
            end else begin
              state <= ST_WAIT_PC;
            end
          end
        end
        ST_WAIT_PC, ST_HALTED: begin
        end
        default: begin
          state <= ST_HALTED;
        end
      endcase
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = addr;
  assign instr_valid_o = valid;
  assign icode_o       = icode;
  assign ifun_o        = ifun;
  assign rA_o          = ra;
  assign rB_o          = rb;
  assign valC_o        = valc;
  assign valP_o        = valp;
  assign pc_o          = pc;
  assign stat_o        = stat;

endmodule

`default_nettype wire

// File: tb/tb_y86_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_y86_fetch_unit: directed vector bench for y86_fetch_unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp, pc;
  logic        pc_load;
  logic [63:0] pc_next;
  logic [2:0]  stat;

  y86_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata), .imem_err_i(imem_err),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .icode_o(icode), .ifun_o(ifun), .rA_o(ra), .rB_o(rb),
    .valC_o(valc), .valP_o(valp), .pc_o(pc),
    .pc_load_i(pc_load), .pc_next_i(pc_next), .stat_o(stat)
  );

  always #5 clk = ~clk;

  // Byte memory model, addressed by the low address byte.
  logic [7:0]  mem [256];
  int          mem_delay = 0;
  int          wait_cnt  = 0;
  logic        mem_en    = 1'b1;
  logic        err_en    = 1'b0;
  logic [63:0] err_addr  = 64'h0;

  always @(negedge clk) begin
    if (imem_rvalid) wait_cnt = 0;
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = 8'h00;
    if (mem_en && imem_req === 1'b1) begin
      if (wait_cnt >= mem_delay) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem[imem_addr[7:0]];
        imem_err    = err_en && (imem_addr == err_addr);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put64(input int a, input logic [63:0] w);
    for (int i = 0; i < 8; i++) mem[a + i] = w[8*i +: 8];
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (instr_valid !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (instr_valid !== 1'b1) chk("wait_valid_bound", {63'd0, instr_valid}, 64'd1);
  endtask

  task automatic do_load(input logic [63:0] target);
    @(negedge clk);
    pc_load = 1'b1;
    pc_next = target;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_noreq(input string name);
    int n;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (imem_req) n++;
    end
    chk(name, 64'(n), 64'd0);
  endtask

  typedef struct {
    logic [63:0] pc;
    int          delay;
    int          cycles;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } vec_t;

  vec_t vec [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lat;

    rst = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; pc_next = 64'h0;
    imem_rvalid = 1'b0; imem_rdata = 8'h0; imem_err = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h30; mem[8'h01] = 8'hF3; put64(8'h02, 64'd10);
    mem[8'h20] = 8'h70; put64(8'h21, 64'h100);
    mem[8'h40] = 8'h40; mem[8'h41] = 8'h12; put64(8'h42, 64'h1122334455667788);
    mem[8'h50] = 8'h60; mem[8'h51] = 8'h01;
    mem[8'h60] = 8'h90;
    mem[8'h70] = 8'h10;
    mem[8'h80] = 8'h24; mem[8'h81] = 8'h56;
    mem[8'h90] = 8'h80; put64(8'h91, 64'hDEADBEEF);
    mem[8'hA0] = 8'h50; mem[8'hA1] = 8'hAB; put64(8'hA2, 64'd8);
    mem[8'hB0] = 8'hA0; mem[8'hB1] = 8'h3F;
    mem[8'hC0] = 8'h61; mem[8'hC1] = 8'h23;
    mem[8'hD0] = 8'hC0;
    mem[8'hE0] = 8'h00;
    mem[8'hFF] = 8'h10;

    //             pc                    dly cyc icode ifun  rA     rB     valC                   valP
    vec[0]  = '{64'h0,                 0, 11, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10,                64'd10};
    vec[1]  = '{64'h20,                0, 10, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100,               64'h29};
    vec[2]  = '{64'h40,                0, 11, 4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788,  64'h4A};
    vec[3]  = '{64'h60,                0,  2, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h61};
    vec[4]  = '{64'h70,                0,  2, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h71};
    vec[5]  = '{64'h80,                0,  3, 4'h2, 4'h4, 4'h5, 4'h6, 64'h0,                 64'h82};
    vec[6]  = '{64'h90,                0, 10, 4'h8, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF,          64'h99};
    vec[7]  = '{64'hA0,                0, 11, 4'h5, 4'h0, 4'hA, 4'hB, 64'd8,                 64'hAA};
    vec[8]  = '{64'hB0,                0,  3, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0,                 64'hB2};
    vec[9]  = '{64'hC0,                2,  7, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0,                 64'hC2};
    vec[10] = '{64'hFFFFFFFFFFFFFFFF,  0,  2, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h0};

    repeat (3) @(negedge clk);
    chk("rst_pc",    pc, 64'h0);
    chk("rst_req",   {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_icode", {60'd0, icode}, 64'h0);
    chk("rst_ifun",  {60'd0, ifun}, 64'h0);
    chk("rst_rA",    {60'd0, ra}, 64'hF);
    chk("rst_rB",    {60'd0, rb}, 64'hF);
    chk("rst_valC",  valc, 64'h0);
    chk("rst_valP",  valp, 64'h0);
    chk("rst_stat",  {61'd0, stat}, 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      mem_delay = vec[i].delay;
      if (i != 0) do_load(vec[i].pc);
      wait_valid(cyc);
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vec[i].cycles));
      chk($sformatf("v%0d_pc", i),    pc, vec[i].pc);
      chk($sformatf("v%0d_icode", i), {60'd0, icode}, {60'd0, vec[i].icode});
      chk($sformatf("v%0d_ifun", i),  {60'd0, ifun},  {60'd0, vec[i].ifun});
      chk($sformatf("v%0d_rA", i),    {60'd0, ra},    {60'd0, vec[i].ra});
      chk($sformatf("v%0d_rB", i),    {60'd0, rb},    {60'd0, vec[i].rb});
      chk($sformatf("v%0d_valC", i),  valc, vec[i].valc);
      chk($sformatf("v%0d_valP", i),  valp, vec[i].valp);
      chk($sformatf("v%0d_stat", i),  {61'd0, stat}, 64'd1);
      handshake();
      chk($sformatf("v%0d_valid_drop", i), {63'd0, instr_valid}, 64'd0);
      mem_delay = 0;
    end

    // Slow memory, stalled consumer, and an ignored pc_load while DONE.
    mem_delay = 3;
    do_load(64'h50);
    wait_valid(cyc);
    chk("slow_cycles", 64'(cyc), 64'd9);
    mem_delay = 0;
    for (int c = 0; c < 5; c++) begin
      pc_load = (c == 2);
      pc_next = 64'h999;
      @(negedge clk);
      chk($sformatf("stall_c%0d", c),
          {15'd0, instr_valid, icode, ifun, ra, rb, valp[15:0], pc[15:0]},
          {15'd0, 1'b1, 4'h6, 4'h0, 4'h0, 4'h1, 16'h0052, 16'h0050});
    end
    pc_load = 1'b0;

    // Handshake and next-PC strobe in the same cycle.
    @(negedge clk);
    instr_ready = 1'b1; pc_load = 1'b1; pc_next = 64'h40;
    @(negedge clk);
    instr_ready = 1'b0; pc_load = 1'b0;
    chk("hl_pc",    pc, 64'h40);
    chk("hl_valid", {63'd0, instr_valid}, 64'd0);
    chk("hl_rB",    {60'd0, rb}, 64'hF);
    chk("hl_valP",  valp, 64'h0);
    lat = 0;
    while (imem_req !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hl_req_lat", 64'(lat), 64'd1);
    chk("hl_addr", imem_addr, 64'h40);
    wait_valid(cyc);
    chk("hl_valC", valc, 64'h1122334455667788);
    chk("hl_valP2", valp, 64'h4A);
    handshake();

    // Address error on the 4th constant byte.
    err_en = 1'b1; err_addr = 64'h24;
    do_load(64'h20);
    wait_valid(cyc);
    err_en = 1'b0;
    chk("err_cycles", 64'(cyc), 64'd6);
    chk("err_stat",   {61'd0, stat}, 64'd3);
    chk("err_icode",  {60'd0, icode}, 64'h7);
    chk("err_valC",   valc, 64'h100);
    chk("err_valP",   valp, 64'h29);
    handshake();
    check_noreq("err_halted_noreq");
    chk("err_halted_stat",  {61'd0, stat}, 64'd3);
    chk("err_halted_valid", {63'd0, instr_valid}, 64'd0);

    // Reset in the middle of the constant bytes.
    pulse_reset();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pc",   pc, 64'h0);
    chk("mid_rst_req",  {63'd0, imem_req}, 64'd0);
    chk("mid_rst_valC", valc, 64'h0);
    chk("mid_rst_rB",   {60'd0, rb}, 64'hF);
    rst = 1'b0;
    wait_valid(cyc);
    chk("refetch_cycles", 64'(cyc), 64'd11);
    chk("refetch_valC",   valc, 64'd10);
    chk("refetch_rB",     {60'd0, rb}, 64'h3);
    handshake();

    // Illegal opcode.
    do_load(64'hD0);
    wait_valid(cyc);
    chk("ins_cycles", 64'(cyc), 64'd2);
    chk("ins_stat",   {61'd0, stat}, 64'd4);
    chk("ins_icode",  {60'd0, icode}, 64'hC);
    handshake();
    chk("ins_valid_drop", {63'd0, instr_valid}, 64'd0);
    check_noreq("ins_halted_noreq");
    chk("ins_halted_stat", {61'd0, stat}, 64'd4);

    // halt instruction.
    pulse_reset();
    wait_valid(cyc);
    handshake();
    do_load(64'hE0);
    wait_valid(cyc);
    chk("hlt_stat_done", {61'd0, stat}, 64'd1);
    chk("hlt_icode",     {60'd0, icode}, 64'h0);
    chk("hlt_valP",      valp, 64'hE1);
    handshake();
    chk("hlt_stat",  {61'd0, stat}, 64'd2);
    chk("hlt_valid", {63'd0, instr_valid}, 64'd0);
    check_noreq("hlt_halted_noreq");

`ifdef FETCH_TIMEOUT_EN
    mem_en = 1'b0;
    pulse_reset();
    wait_valid(cyc);
    chk("tmo_cycles", 64'(cyc), 64'd5);
    chk("tmo_stat",   {61'd0, stat}, 64'd3);
    chk("tmo_req",    {63'd0, imem_req}, 64'd0);
    mem_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
